// File: rtl/relu_argmax.sv
// ReLU + argmax classification stage: captures one vector, clamps negatives, scans for the max.
// Optional SHUFFLE_SCAN_EN randomizes the scan start position with a 16-bit LFSR.
module relu_argmax #(
    parameter int OUTPUT_SIZE = 10,
    parameter int WIDTH       = 16,
    parameter int IDX_W       = $clog2(OUTPUT_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data [OUTPUT_SIZE-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] class_idx,
    output logic [WIDTH-1:0] max_val
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_class_idx;
    logic [WIDTH-1:0] r_max_val;
    logic [WIDTH-1:0] r_vec [OUTPUT_SIZE-1:0];
    logic [IDX_W-1:0] r_pos;
    logic [IDX_W-1:0] r_count;
    logic [WIDTH-1:0] r_best_val;
    logic [IDX_W-1:0] r_best_idx;

    logic             w_accept;
    logic [IDX_W-1:0] w_start;
    logic [WIDTH-1:0] w_elem;
    logic             w_take;
    logic [WIDTH-1:0] w_best_val_nxt;
    logic [IDX_W-1:0] w_best_idx_nxt;
    logic [IDX_W-1:0] w_pos_nxt;

    assign w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;

`ifdef SHUFFLE_SCAN_EN
    logic [15:0]      r_lfsr;
    logic             w_lfsr_fb;
    logic [IDX_W-1:0] w_lfsr_raw;

    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_raw = r_lfsr[IDX_W-1:0];

    // Free-running Fibonacci LFSR (taps 16,14,13,11).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Fold the raw LFSR bits into the legal index range.
    always_comb begin
        w_start = w_lfsr_raw;
        if (int'(w_lfsr_raw) >= OUTPUT_SIZE) begin
            w_start = w_lfsr_raw - IDX_W'(OUTPUT_SIZE);
        end else begin
            w_start = w_lfsr_raw;
        end
    end
`else
    assign w_start = '0;
`endif

    // Best-so-far update; equal values keep the lower index so scan order never matters.
    always_comb begin
        w_elem = r_vec[r_pos];
        w_take = (r_count == '0) || (w_elem > r_best_val) ||
                 ((w_elem == r_best_val) && (r_pos < r_best_idx));
        if (w_take) begin
            w_best_val_nxt = w_elem;
            w_best_idx_nxt = r_pos;
        end else begin
            w_best_val_nxt = r_best_val;
            w_best_idx_nxt = r_best_idx;
        end
        if (r_pos == LAST_IDX) begin
            w_pos_nxt = '0;
        end else begin
            w_pos_nxt = r_pos + IDX_W'(1);
        end
    end

    // Vector capture with ReLU clamp applied on the way in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                r_vec[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                r_vec[i] <= in_data[i][WIDTH-1] ? '0 : in_data[i];
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_class_idx <= '0;
            r_max_val   <= '0;
            r_pos       <= '0;
            r_count     <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pos      <= w_start;
                        r_count    <= '0;
                        r_best_val <= '0;
                        r_best_idx <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SCAN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_best_val <= w_best_val_nxt;
                    r_best_idx <= w_best_idx_nxt;
                    r_pos      <= w_pos_nxt;
                    r_count    <= r_count + IDX_W'(1);
                    if (r_count == LAST_IDX) begin
                        r_class_idx <= w_best_idx_nxt;
                        r_max_val   <= w_best_val_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign class_idx = r_class_idx;
    assign max_val   = r_max_val;

endmodule

// File: tb/tb_relu_argmax.sv
// Self-checking bench for relu_argmax: vector table, handshake corner cases, random back-to-back.
module tb_relu_argmax;
    localparam int N = 10;
    localparam int W = 16;
`ifdef SHUFFLE_SCAN_EN
    localparam int TIE_REPS = 200;
`else
    localparam int TIE_REPS = 20;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data [N-1:0];
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   class_idx;
    logic [W-1:0] max_val;

    relu_argmax #(.OUTPUT_SIZE(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .max_val(max_val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] d;
        logic [3:0]     idx;
        logic [W-1:0]   val;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N*W-1:0] d);
        for (int i = 0; i < N; i++) in_data[i] = d[i*W +: W];
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] a [N]);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    // Reference: ReLU each element, strict greater-than from index 0 => lowest index wins ties.
    function automatic logic [19:0] model(input logic [N*W-1:0] d);
        int best = 0;
        int bi = 0;
        for (int i = 0; i < N; i++) begin
            int v = int'($signed(d[i*W +: W]));
            if (v < 0) v = 0;
            if (v > best) begin
                best = v;
                bi = i;
            end
        end
        return {4'(bi), 16'(best)};
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) d[i*W +: W] = 16'($urandom);
            else d[i*W +: W] = 16'($urandom_range(0, 20));
        end
        return d;
    endfunction

    // Accept a vector, then wait for the result while checking latency and in_ready.
    task automatic run_one(input string name, input logic [N*W-1:0] d);
        int k = 0;
        int lat = 1;
        int rdy_hi = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk({name, "_ready_wait"}, 32'(k < 50), 32'd1);
        drive(d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drive(rand_vec());
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_hi++;
            tick();
            lat++;
        end
        if (in_ready) rdy_hi++;
        chk({name, "_latency"}, 32'(lat), 32'd11);
        chk({name, "_in_ready_low"}, 32'(rdy_hi), 32'd0);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    vec_t           tbl [7];
    logic [W-1:0]   t [N];
    logic [N*W-1:0] cur_d;
    logic [19:0]    exp_r;
    logic [19:0]    q [$];

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive('0);

        t = '{16'd5, 16'hFFFD, 16'd9, 16'd2, 16'd0, 16'd1, 16'd7, 16'hFFF8, 16'd4, 16'd3};
        tbl[0] = '{d: pack(t), idx: 4'd2, val: 16'd9};
        t = '{16'h8000, 16'hFFFF, 16'h8001, 16'hFFFE, 16'hC000, 16'h9000, 16'hF000, 16'hFF00, 16'hA5A5, 16'h8123};
        tbl[1] = '{d: pack(t), idx: 4'd0, val: 16'd0};
        t = '{16'd10, 16'd20, 16'd30, 16'd100, 16'd5, 16'd99, 16'd0, 16'd100, 16'hFFFF, 16'd50};
        tbl[2] = '{d: pack(t), idx: 4'd3, val: 16'd100};
        t = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[3] = '{d: pack(t), idx: 4'd0, val: 16'd0};
        t = '{16'hFFFB, 16'd0, 16'd0, 16'h7FFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'h7FFF};
        tbl[4] = '{d: pack(t), idx: 4'd3, val: 16'h7FFF};
        t = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
        tbl[5] = '{d: pack(t), idx: 4'd9, val: 16'd10};
        t = '{16'd50, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd50};
        tbl[6] = '{d: pack(t), idx: 4'd0, val: 16'd50};

        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_max_val", 32'(max_val), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            run_one($sformatf("tbl%0d", v), tbl[v].d);
            chk($sformatf("tbl%0d_idx", v), 32'(class_idx), 32'(tbl[v].idx));
            chk($sformatf("tbl%0d_val", v), 32'(max_val), 32'(tbl[v].val));
            handshake($sformatf("tbl%0d", v));
        end

        for (int r = 0; r < TIE_REPS; r++) begin
            for (int i = 0; i < N; i++) begin
                if (i == 3 || i == 7) t[i] = 16'd100;
                else if ($urandom_range(0, 3) == 0) t[i] = 16'h8000 | 16'($urandom);
                else t[i] = 16'($urandom_range(0, 99));
            end
            run_one("tie", pack(t));
            chk("tie_idx", 32'(class_idx), 32'd3);
            chk("tie_val", 32'(max_val), 32'd100);
            handshake("tie");
        end

        // Result held while out_ready stays low; a pending in_valid must be ignored.
        run_one("hold", tbl[0].d);
        in_valid = 1'b1;
        drive(tbl[5].d);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_idx", 32'(class_idx), 32'd2);
            chk("hold_val", 32'(max_val), 32'd9);
        end
        in_valid = 1'b0;
        handshake("hold");
        begin
            int ghost = 0;
            for (int c = 0; c < 15; c++) begin
                tick();
                if (out_valid) ghost++;
            end
            chk("hold_no_ghost_result", 32'(ghost), 32'd0);
        end

        // Reset in the middle of a scan discards the vector.
        drive(tbl[4].d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_class_idx", 32'(class_idx), 32'd0);
        chk("midrst_max_val", 32'(max_val), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("midrst_no_result", 32'(seen), 32'd0);
        end
        out_ready = 1'b0;
        t = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        run_one("after_rst", pack(t));
        chk("after_rst_idx", 32'(class_idx), 32'd9);
        chk("after_rst_val", 32'(max_val), 32'd1);
        handshake("after_rst");

        // Back-to-back random vectors, both handshakes held high.
        begin
            int cyc = 0;
            int last_acc = -1;
            int n_acc = 0;
            int n_res = 0;
            int bad_space = 0;
            int bad_res = 0;
            logic prev_rdy;
            cur_d = rand_vec();
            drive(cur_d);
            in_valid = 1'b1;
            out_ready = 1'b1;
            prev_rdy = in_ready;
            while (n_res < 50 && cyc < 2000) begin
                tick();
                cyc++;
                if (prev_rdy && in_valid) begin
                    if (last_acc >= 0 && (cyc - last_acc) != 12) begin
                        bad_space++;
                        $display("FAIL b2b_spacing: got %0d expected 12", cyc - last_acc);
                    end
                    last_acc = cyc;
                    q.push_back(model(cur_d));
                    n_acc++;
                    if (n_acc == 50) in_valid = 1'b0;
                    cur_d = rand_vec();
                    drive(cur_d);
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        bad_res++;
                        $display("FAIL b2b_unexpected_result: got idx %0d val %0d", class_idx, max_val);
                    end else begin
                        exp_r = q.pop_front();
                        if ({class_idx, max_val} !== exp_r) begin
                            bad_res++;
                            $display("FAIL b2b_result: got idx %0d val %0d expected idx %0d val %0d",
                                     class_idx, max_val, exp_r[19:16], exp_r[15:0]);
                        end
                    end
                    n_res++;
                end
                prev_rdy = in_ready;
            end
            n_cmp++;
            if (bad_space != 0) n_bad++;
            n_cmp++;
            if (bad_res != 0) n_bad++;
            chk("b2b_result_count", 32'(n_res), 32'd50);
            in_valid = 1'b0;
            out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
